// File: rtl/instr_decode_if.sv
// Bus between the instruction register/decoder and the rest of the multicycle CPU.
// The CPU side (fetch, control FSM, datapath) drives through master; the decoder uses slave.
interface instr_decode_if #(
    parameter int CNT_W = 32
);
    logic             irWe;
    logic [31:0]      memData;
    logic [3:0]       pcHi;
    logic             errClr;
    logic [3:0]       cmd;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [31:0]      sxi;
    logic [31:0]      sxis;
    logic [31:0]      jTarget;
    logic             irValid;
    logic             illegal;
    logic             errSticky;
    logic [31:0]      badInstr;
    logic [CNT_W-1:0] instrCount;

    modport master (
        output irWe, memData, pcHi, errClr,
        input  cmd, rs, rt, rd, sxi, sxis, jTarget,
               irValid, illegal, errSticky, badInstr, instrCount
    );

    modport slave (
        input  irWe, memData, pcHi, errClr,
        output cmd, rs, rt, rd, sxi, sxis, jTarget,
               irValid, illegal, errSticky, badInstr, instrCount
    );
endinterface

// File: rtl/instr_decode.sv
// Instruction register and decoder for the multicycle MIPS CPU: command code, fields,
// sticky illegal-encoding error with first-offender capture, and a fetch counter.
module instr_decode #(
    parameter int CNT_W = 32
) (
    input  logic           clk,
    input  logic           rstN,
    instr_decode_if.slave  bus
);
    typedef enum logic [3:0] {
        C_LW = 4'd0, C_SW = 4'd1, C_J = 4'd2, C_JR = 4'd3, C_JAL = 4'd4,
        C_BEQ = 4'd5, C_BNE = 4'd6, C_XORI = 4'd7, C_ADDI = 4'd8,
        C_ADD = 4'd9, C_SUB = 4'd10, C_SLT = 4'd11, C_ILL = 4'd15
    } cmd_e;

    // Only op and funct participate; shamt and the unused register fields are don't-care.
    function automatic cmd_e decode(input logic [31:0] w);
        cmd_e c;
        c = C_ILL;
        case (w[31:26])
            6'h23: c = C_LW;
            6'h2B: c = C_SW;
            6'h02: c = C_J;
            6'h03: c = C_JAL;
            6'h04: c = C_BEQ;
            6'h05: c = C_BNE;
            6'h0E: c = C_XORI;
            6'h08: c = C_ADDI;
            6'h00: begin
                case (w[5:0])
                    6'h08:   c = C_JR;
                    6'h20:   c = C_ADD;
                    6'h22:   c = C_SUB;
                    6'h2A:   c = C_SLT;
                    default: c = C_ILL;
                endcase
            end
            default: c = C_ILL;
        endcase
        return c;
    endfunction

    logic [31:0]      ir;
    logic             irValid;
    logic             errSticky;
    logic [31:0]      badInstr;
    logic [CNT_W-1:0] instrCount;
    logic             loadIll;
    cmd_e             irCmd;

    assign loadIll = bus.irWe && (decode(bus.memData) == C_ILL);
    assign irCmd   = decode(ir);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ir         <= '0;
            irValid    <= 1'b0;
            errSticky  <= 1'b0;
            badInstr   <= '0;
            instrCount <= '0;
        end else begin
            if (bus.irWe) begin
                ir         <= bus.memData;
                irValid    <= 1'b1;
                instrCount <= instrCount + 1'b1;
            end
            // Set beats clear; a clear at the same edge re-arms capture of this word.
            if (loadIll) begin
                errSticky <= 1'b1;
                if (!errSticky || bus.errClr)
                    badInstr <= bus.memData;
            end else if (bus.errClr) begin
                errSticky <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.cmd        = irValid ? irCmd : C_ILL;
        bus.illegal    = irValid && (irCmd == C_ILL);
        bus.rs         = ir[25:21];
        bus.rt         = ir[20:16];
        bus.rd         = ir[15:11];
        bus.sxi        = {{16{ir[15]}}, ir[15:0]};
        bus.sxis       = {{14{ir[15]}}, ir[15:0], 2'b00};
        bus.jTarget    = {bus.pcHi, ir[25:0], 2'b00};
        bus.irValid    = irValid;
        bus.errSticky  = errSticky;
        bus.badInstr   = badInstr;
        bus.instrCount = instrCount;
    end
endmodule

// File: doc/instr_decode.md
# instr_decode

Instruction register and decoder for the multicycle MIPS CPU. It captures the fetched word on `irWe` and produces the 4-bit command code consumed by the control FSM. It also extracts register fields, immediates and the jump target for the datapath. It flags unsupported encodings with a sticky error, captures the first offending word, and counts fetched instructions for the bench and debug.

## Interface
- `CNT_W`, default 32: width of the fetched-instruction counter.
- `clk`  in  1: clock, rising-edge.
- `rstN`  in  1: asynchronous active-low reset.
- `irWe`  in  1: load `memData` into the instruction register (IR) at this edge.
- `memData`  in  32: instruction word from memory.
- `pcHi`  in  4: PC[31:28], used to build the jump target.
- `errClr`  in  1: clear the sticky error.
- `cmd`  out  4: command code. LW=0, SW=1, J=2, JR=3, JAL=4, BEQ=5, BNE=6, XORI=7, ADDI=8, ADD=9, SUB=10, SLT=11, ILLEGAL=15.
- `rs`, `rt`, `rd`  out  5 each: IR[25:21], IR[20:16], IR[15:11].
- `sxi`  out  32: sign-extended IR[15:0].
- `sxis`  out  32: `sxi` << 2.
- `jTarget`  out  32: {pcHi, IR[25:0], 2'b00}.
- `irValid`  out  1: IR holds a fetched word.
- `illegal`  out  1: IR is valid and decodes to ILLEGAL.
- `errSticky`  out  1: an illegal word has been loaded since reset or the last `errClr`.
- `badInstr`  out  32: first illegal word loaded while `errSticky` was clear.
- `instrCount`  out  CNT_W: number of `irWe` loads, modulo 2^CNT_W.

## Operation
- Registers: IR, `irValid`, `errSticky`, `badInstr`, `instrCount`. All other outputs are combinational from IR.
- Reset values (asynchronous on `rstN`=0):
  - IR=0, `irValid`=0, `errSticky`=0, `badInstr`=0, `instrCount`=0.
  - Therefore `cmd`=15, `illegal`=0, `rs`/`rt`/`rd`=0, `sxi`/`sxis`=0, and `jTarget`={pcHi,28'b0}.
- Decode of op=IR[31:26] and funct=IR[5:0]:
  - op 0x23 → LW; 0x2B → SW; 0x02 → J; 0x03 → JAL; 0x04 → BEQ; 0x05 → BNE; 0x0E → XORI; 0x08 → ADDI.
  - op 0x00 with funct 0x08 → JR; 0x20 → ADD; 0x22 → SUB; 0x2A → SLT.
  - Anything else → 15.
- `cmd`=15 whenever `irValid`=0. `illegal` = `irValid` & (decoded code == 15).
- Decode ignores shamt, and ignores rt/rd on JR. Only op and funct matter.
- On an `irWe` edge:
  - IR ← `memData`, `irValid` ← 1, `instrCount` ← `instrCount`+1, wrapping at all-ones to 0.
  - If `memData` decodes illegal: `errSticky` ← 1. If `errSticky` was 0 before the edge, also `badInstr` ← `memData`.
- `errClr` at an edge: `errSticky` ← 0; `badInstr` is held.
- `errClr` and an illegal load at the same edge: set wins. `errSticky`=1 and `badInstr` ← `memData`.
- IR holds its value when `irWe`=0. Reloading an identical word still increments the count.

## Timing
- Latency: a word presented with `irWe` at edge k is visible on `cmd` and all field outputs from just after edge k, through the cycle until the next load. This meets the FSM rule that `cmd` is valid in the cycle after instruction fetch.
- `errSticky` and `badInstr` update at the same edge as the IR load; there is no extra cycle of delay.
- `pcHi` is combinational into `jTarget`. The FSM samples `jTarget` only in its jump-decode cycle.
- Reset mid-operation: all registers clear immediately, with no clock edge needed. `cmd` reads 15 until the next `irWe`.
- `memData` matters only at edges where `irWe`=1. `errClr` matters only at clock edges.

## Test plan
- Reset, no loads: `cmd`=15, `irValid`=0, `illegal`=0, `instrCount`=0, `errSticky`=0.
- Load 0x8D090004 (lw $t1,4($t0)) → next cycle `cmd`=0, `rs`=8, `rt`=9, `sxi`=0x00000004, `instrCount`=1.
- Load 0x1109FFFE (beq $t0,$t1,-2) → `cmd`=5, `sxi`=0xFFFFFFFE, `sxis`=0xFFFFFFF8. Then with `pcHi`=0x4, load 0x0C000010 (jal) → `cmd`=4, `jTarget`=0x40000040.
- R-type sweep: 0x012A4020 → 9 (ADD), 0x012A4022 → 10 (SUB), 0x012A402A → 11 (SLT), 0x01000008 → 3 (JR), 0x012A4024 (AND) → 15 with `illegal`=1.
- Error capture:
  - Load 0xFC000000 → `errSticky`=1, `badInstr`=0xFC000000.
  - Then load 0x012A4025 → `badInstr` stays 0xFC000000.
  - Then `errClr` alone → `errSticky`=0.
  - Then `errClr` together with an illegal load of 0x012A4025 → `errSticky`=1, `badInstr`=0x012A4025.
- Wrap and async reset:
  - With CNT_W=4, perform 16 loads → `instrCount`=0.
  - Assert `rstN`=0 mid-cycle between edges → all registered outputs clear immediately and `cmd`=15.
